// File: rtl/fetch_unit.sv
// fetch_unit: fetch-queue front end; define FETCH_BTFN_PREDICT_EN for static
// backward-taken / JAL-taken prediction, otherwise the pc always advances by 4.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_pred_taken
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic          pred_mem  [DEPTH];
    logic          pop, push, pred;
    logic [31:0]   next_pc;

`ifdef FETCH_BTFN_PREDICT_EN
    logic        is_b, is_j;
    logic [31:0] b_imm, j_imm;
    always_comb begin
        is_b    = imem_data[6:0] == 7'b1100011 && imem_data[31];
        is_j    = imem_data[6:0] == 7'b1101111;
        b_imm   = {{20{imem_data[31]}}, imem_data[7], imem_data[30:25], imem_data[11:8], 1'b0};
        j_imm   = {{12{imem_data[31]}}, imem_data[19:12], imem_data[20], imem_data[30:21], 1'b0};
        pred    = is_b || is_j;
        next_pc = pc_q + (is_b ? b_imm : is_j ? j_imm : 32'd4);
    end
`else
    always_comb begin
        pred    = 1'b0;
        next_pc = pc_q + 32'd4;
    end
`endif

    assign imem_addr      = pc_q;
    assign out_valid      = cnt_q != '0;
    // Head fields are forced to zero when empty so they read 0 during reset.
    assign out_instr      = out_valid ? instr_mem[rd_q] : '0;
    assign out_pc         = out_valid ? pc_mem[rd_q] : '0;
    assign out_pred_taken = out_valid && pred_mem[rd_q];

    always_comb begin
        pop   = out_valid && out_ready && !redirect_valid;
        push  = !redirect_valid && (cnt_q != CW'(DEPTH) || pop);
        cnt_d = redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
        rd_d  = redirect_valid ? '0 : rd_q + AW'(pop);
        wr_d  = redirect_valid ? '0 : wr_q + AW'(push);
        pc_d  = redirect_valid ? (redirect_pc & ~32'd3) : push ? next_pc : pc_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_q]    <= pc_q;
            instr_mem[wr_q] <= imem_data;
            pred_mem[wr_q]  <= pred;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit (default parameters).
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem_addr, imem_data;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid, out_ready = 1'b0, out_pred_taken;
    logic [31:0] out_instr, out_pc;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } ent_t;

    ent_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_pc(out_pc), .out_pred_taken(out_pred_taken)
    );

    always #5 clk = ~clk;

    // BEQ x0,x0,-8 lives at 0x20; every other word is an OP-IMM tagged by its address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a == 32'h20 ? 32'hFE00_0CE3 : {a[24:0], 7'b0010011};
    endfunction

    function automatic logic pred_f(input logic [31:0] a);
`ifdef FETCH_BTFN_PREDICT_EN
        return a == 32'h20;
`else
        return a != a;
`endif
    endfunction

    assign imem_data = mem_f(imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input logic [31:0] a);
        sb.push_back('{pc: a, instr: mem_f(a), pred: pred_f(a)});
    endtask

    task automatic pop_chk();
        ent_t e;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("valid", 32'(out_valid), 32'd1);
            chk("pc", out_pc, e.pc);
            chk("instr", out_instr, e.instr);
            chk("pred", 32'(out_pred_taken), 32'(e.pred));
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_pc", out_pc, 32'h0);
        chk("rst_instr", out_instr, 32'h0);
        chk("rst_pred", 32'(out_pred_taken), 32'd0);
        @(negedge clk);
        chk("rst_hold_valid", 32'(out_valid), 32'd0);
        chk("rst_hold_addr", imem_addr, 32'h0);
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_push(32'(i * 4));
        repeat (4) begin
            @(negedge clk);
            pop_chk();
        end
        // Backpressure: restart from reset, then hold decode off.
        reset = 1'b1;
        out_ready = 1'b0;
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("stall_addr5", imem_addr, 32'h10);
        repeat (5) @(negedge clk);
        chk("stall_addr10", imem_addr, 32'h10);
        for (int i = 0; i < 5; i++) exp_push(32'(i * 4));
        out_ready = 1'b1;
        repeat (5) begin
            pop_chk();
            @(negedge clk);
        end
        // Queue is full here (push and pop every edge); redirect with out_ready high.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0103;
        sb.delete();
        @(negedge clk);
        chk("redir_valid", 32'(out_valid), 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        redirect_valid = 1'b0;
        exp_push(32'h100);
        exp_push(32'h104);
        repeat (2) begin
            @(negedge clk);
            pop_chk();
        end
        // Wrap through 2^32.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        sb.delete();
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFF8);
        exp_push(32'hFFFF_FFF8);
        exp_push(32'hFFFF_FFFC);
        exp_push(32'h0);
        repeat (3) begin
            @(negedge clk);
            pop_chk();
        end
        // Prediction on the BEQ at 0x20.
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        out_ready = 1'b0;
        sb.delete();
        @(negedge clk);
        redirect_valid = 1'b0;
        @(negedge clk);
`ifdef FETCH_BTFN_PREDICT_EN
        chk("pred_next", imem_addr, 32'h18);
`else
        chk("pred_next", imem_addr, 32'h24);
`endif
        exp_push(32'h20);
        pop_chk();
        // Async reset between edges with three entries queued.
        repeat (2) @(negedge clk);
        chk("pre_areset_valid", 32'(out_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("areset_valid", 32'(out_valid), 32'd0);
        chk("areset_addr", imem_addr, 32'h0);
        chk("areset_pc", out_pc, 32'h0);
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        exp_push(32'h0);
        exp_push(32'h4);
        repeat (2) begin
            @(negedge clk);
            pop_chk();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, giving the fetch-queue entries (power of two, 2..16).
REQ-003 SHALL have port clk  in  1  clock, all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port imem_addr  out  32  byte address presented to the instruction memory.
REQ-006 SHALL have port imem_data  in  32  instruction returned combinationally for imem_addr in the same cycle.
REQ-007 SHALL have port redirect_valid  in  1  branch-resolution redirect request.
REQ-008 SHALL have port redirect_pc  in  32  redirect target address.
REQ-009 SHALL have port out_valid  out  1  queue head holds a valid instruction.
REQ-010 SHALL have port out_ready  in  1  decode accepts the head this cycle.
REQ-011 SHALL have port out_instr  out  32  head instruction word.
REQ-012 SHALL have port out_pc  out  32  head instruction address.
REQ-013 SHALL have port out_pred_taken  out  1  head was predicted taken.

Function
REQ-014 SHALL hold a 32-bit pc register and drive imem_addr = pc combinationally.
REQ-015 SHALL hold a DEPTH-entry in-order FIFO of {pc, instr, pred_taken} with a count of 0..DEPTH.
REQ-016 SHALL assert out_valid iff count != 0 and drive out_instr/out_pc/out_pred_taken from the head; head fields are don't-care when out_valid is low.
REQ-017 SHALL pop the head on a rising edge iff out_valid && out_ready.
REQ-018 SHALL fire a fetch (push {pc, imem_data, pred} and advance pc) iff redirect_valid is low and (count < DEPTH or a pop occurs that cycle).
REQ-019 SHALL hold pc and push nothing when the queue is full with no pop (stall); imem_addr stays constant during the stall.
REQ-020 SHALL, with redirect_valid high, flush the queue (count <= 0), set pc <= {redirect_pc[31:2], 2'b00}, and neither push nor pop that cycle, regardless of out_ready.
REQ-021 SHALL compute pc+4 and branch targets modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000.
REQ-022 SHALL have one-cycle fetch latency: an instruction fetched at edge N is visible on the outputs from edge N onward when the queue was empty.
REQ-023 SHALL, on simultaneous push and pop with count == DEPTH, keep count at DEPTH and preserve order.

Reset
REQ-024 SHALL, while reset is high, asynchronously set pc = RESET_PC, count = 0, and queue pointers = 0.
REQ-025 SHALL hold out_valid = 0 and imem_addr = RESET_PC during reset; out_instr/out_pc/out_pred_taken SHALL read 0.
REQ-026 SHALL, on reset asserted mid-stall or mid-redirect, discard all queued entries; the first fetch after reset deassertion is at RESET_PC.

Configuration
REQ-027 SHALL implement static prediction iff macro FETCH_BTFN_PREDICT_EN is defined.
REQ-028 SHALL, with FETCH_BTFN_PREDICT_EN defined, set next pc = pc + sign-extended B-immediate with pred=1 when imem_data[6:0] == 7'b1100011 and imem_data[31] == 1.
REQ-029 SHALL, with FETCH_BTFN_PREDICT_EN defined, set next pc = pc + sign-extended J-immediate with pred=1 when imem_data[6:0] == 7'b1101111.
REQ-030 SHALL otherwise use next pc = pc + 4, pred=0; without the macro, next pc = pc + 4 and out_pred_taken = 0 always.

Verification
REQ-031 SHALL pass reset test: reset release, out_ready=1, memory of NOPs -> out_pc sequence 0,4,8,12 on consecutive cycles, out_valid high from the first edge.
REQ-032 SHALL pass backpressure test: out_ready=0 for 10 cycles with DEPTH=4 -> count saturates at 4, imem_addr frozen at 16, then out_ready=1 drains pc 0,4,8,12,16 with no loss or duplication.
REQ-033 SHALL pass redirect test: redirect_valid=1, redirect_pc=32'h0000_0103 with queue full and out_ready=1 -> next cycle out_valid=0, imem_addr=32'h0000_0100, then out_pc=32'h100.
REQ-034 SHALL pass wrap test: RESET_PC=32'hFFFF_FFF8 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-035 SHALL pass prediction test (macro on): BEQ with imm=-8 at pc 32'h20 -> next fetch 32'h18, out_pred_taken=1; macro off -> next fetch 32'h24, out_pred_taken=0.
REQ-036 SHALL pass async-reset test: reset pulsed between clock edges while count=3 -> out_valid falls immediately, imem_addr=RESET_PC without a clock edge.
